// File: rtl/sfifo_fwft.sv
// sfifo_fwft: synchronous FIFO with first-word-fall-through output.
// All entries live in a 1r1w array; the head register doubles as the
// registered read port, and writes into an empty (or draining-to-empty)
// FIFO bypass straight into it so data shows up one cycle after the push.
module sfifo_fwft #(
  parameter int SFIFODW   = 32,
  parameter int SFIFOAW   = 4,
  parameter int SFIFODP   = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wvalid,
  output logic               wready,
  input  logic [SFIFODW-1:0] wdata,
  output logic               rvalid,
  input  logic               rready,
  output logic [SFIFODW-1:0] rdata,
  output logic [SFIFOAW:0]   count,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam int CW = SFIFOAW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SFIFODP);

  logic [SFIFODW-1:0] mem [SFIFODP];

  logic [SFIFOAW-1:0] wptr_q, wptr_d;
  logic [SFIFOAW-1:0] rptr_q, rptr_d;
  logic [SFIFOAW-1:0] rptr_next;
  logic [CW-1:0]      count_q, count_d;
  logic               rvalid_q, rvalid_d;
  logic [SFIFODW-1:0] rdata_q, rdata_d;
  logic               wready_q, wready_d;
  logic               afull_q, afull_d;
  logic               aempty_q, aempty_d;
  logic               push, pop;

  // Next-state logic: pointers, occupancy, head refill/bypass and flags.
  always_comb begin
    push      = wvalid && wready_q;
    pop       = rvalid_q && rready;
    rptr_next = rptr_q + SFIFOAW'(1);
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + SFIFOAW'(1);
      if (pop)  rptr_d = rptr_next;
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (pop) begin
        if (count_q >= CW'(2)) begin
          rdata_d  = mem[rptr_next];
          rvalid_d = 1'b1;
        end else if (push) begin
          rdata_d  = wdata;
          rvalid_d = 1'b1;
        end else begin
          rvalid_d = 1'b0;
        end
      end else if (!rvalid_q && push) begin
        rdata_d  = wdata;
        rvalid_d = 1'b1;
      end
    end
    wready_d = (count_d != FULL_CNT);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_q] <= wdata;
  end

  // State registers with asynchronous reset to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wready_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      wready_q <= wready_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign wready       = wready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_sfifo_fwft.sv
// tb_sfifo_fwft: directed self-checking bench for sfifo_fwft.
module tb_sfifo_fwft;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;

  int checks;
  int errors;

  sfifo_fwft #(
    .SFIFODW(32), .SFIFOAW(4), .SFIFODP(16), .AFULL_TH(12), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 ns after the edge.
  task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
    wvalid = wv;
    wdata  = wd;
    rready = rr;
    flush  = fl;
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    wvalid = 1'b0;
    wdata  = '0;
    rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_wready", 32'(wready), 32'd1);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_afull", 32'(almost_full), 32'd0);
    checkOutput("reset_aempty", 32'(almost_empty), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);

    $display("[TB] fill 0x00..0x0F");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      checkOutput("fill_rvalid", 32'(rvalid), 32'd1);
      checkOutput("fill_rdata", rdata, 32'h0);
      checkOutput("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
      checkOutput("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
      checkOutput("fill_wready", 32'(wready), 32'((i + 1) != 16));
    end

    $display("[TB] drain full FIFO");
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_rvalid", 32'(rvalid), 32'd1);
      checkOutput("drain_rdata", rdata, 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("drain_count", 32'(count), 32'(15 - i));
      checkOutput("drain_aempty", 32'(almost_empty), 32'((15 - i) <= 2));
    end
    checkOutput("drain_empty_rvalid", 32'(rvalid), 32'd0);

    $display("[TB] streaming across pointer wrap");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    checkOutput("stream_pre_count", 32'(count), 32'd3);
    for (int i = 0; i < 40; i++) begin
      checkOutput("stream_rdata", rdata, 32'h100 + 32'(i));
      applyStimulus(1'b1, 32'h103 + 32'(i), 1'b1, 1'b0);
      checkOutput("stream_count", 32'(count), 32'd3);
      checkOutput("stream_rvalid", 32'(rvalid), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("stream_tail_rdata", rdata, 32'h128 + 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("stream_end_rvalid", 32'(rvalid), 32'd0);
    checkOutput("stream_end_count", 32'(count), 32'd0);

    $display("[TB] full boundary");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd16);
    checkOutput("full_wready", 32'(wready), 32'd0);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0);
    checkOutput("full_pp_count", 32'(count), 32'd15);
    checkOutput("full_pp_wready", 32'(wready), 32'd1);
    for (int i = 1; i < 16; i++) begin
      checkOutput("full_drain_rdata", rdata, 32'h200 + 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("full_drain_rvalid", 32'(rvalid), 32'd0);
    applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0);
    checkOutput("aa_rdata", rdata, 32'hAA);
    checkOutput("aa_count", 32'(count), 32'd1);

    $display("[TB] single-entry push+pop");
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    checkOutput("single_rvalid", 32'(rvalid), 32'd1);
    checkOutput("single_rdata", rdata, 32'h55);
    checkOutput("single_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("single_empty_rvalid", 32'(rvalid), 32'd0);
    checkOutput("single_empty_count", 32'(count), 32'd0);

    $display("[TB] flush at count 9");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    checkOutput("preflush_count", 32'(count), 32'd9);
    applyStimulus(1'b1, 32'h999, 1'b1, 1'b1);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_rvalid", 32'(rvalid), 32'd0);
    checkOutput("flush_wready", 32'(wready), 32'd1);
    checkOutput("flush_aempty", 32'(almost_empty), 32'd1);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    checkOutput("postflush_rvalid", 32'(rvalid), 32'd1);
    checkOutput("postflush_rdata", rdata, 32'h77);
    checkOutput("postflush_count", 32'(count), 32'd1);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 32'h78, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h79, 1'b0, 1'b0);
    checkOutput("prerst_count", 32'(count), 32'd3);
    wvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("arst_rdata", rdata, 32'd0);
    checkOutput("arst_wready", 32'(wready), 32'd1);
    checkOutput("arst_aempty", 32'(almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b0);
    checkOutput("postrst_rdata", rdata, 32'h66);
    checkOutput("postrst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("postrst_empty", 32'(rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_fwft.md
# sfifo_fwft

Parametrised synchronous FIFO with first-word-fall-through output, valid/ready handshakes on both sides, occupancy count and programmable almost-full/almost-empty flags. It is the next generation of the team's small 1r1w-RAM FIFO storage. The block wraps its own 1r1w array (registered read address) plus output staging, so AXI channel buffers can drop it in without external pointer logic.

## Interface
- SFIFODW, 32, data width in bits
- SFIFOAW, 4, pointer width; depth SFIFODP must equal 2**SFIFOAW
- SFIFODP, 16, total capacity in entries, counting entries held in output staging
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..SFIFODP)
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..SFIFODP-1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all contents
- wvalid  in  1  write request
- wready  out  1  space available
- wdata  in  SFIFODW  write data
- rvalid  out  1  rdata holds the oldest entry
- rready  in  1  consumer accepts rdata
- rdata  out  SFIFODW  oldest entry (FWFT)
- count  out  SFIFOAW+1  entries held, 0..SFIFODP
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH

## Operation
- Push occurs when wvalid && wready at a rising edge. Pop occurs when rvalid && rready at a rising edge.
- Order is strict FIFO. No entry is lost or duplicated.
- Storage is an internal SFIFODP-entry 1r1w array with a registered read address: data reads one cycle after the address is presented.
- Output staging (head register, plus prefetch as needed) hides that read latency. Entries in staging count toward count and capacity.
- Write and read pointers are SFIFOAW bits and wrap modulo SFIFODP with no gap.
- count updates each edge:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push+pop
- wready = (count != SFIFODP). It is registered or derived from registered count only, with no combinational path from rready or wvalid.
- Push while full is a normal backpressure case. The write is not performed.
- Pop while empty is impossible, since rvalid=0.
- Simultaneous push+pop when full (count=SFIFODP): the pop proceeds. The push is refused because wready=0, and wready rises the next cycle.
- Simultaneous push+pop when count=1: the popped entry leaves and the new entry becomes head next cycle, with rvalid staying 1.
- flush=1 at an edge: count=0, pointers=0, rvalid=0, wready=1. Any push or pop in the same cycle is discarded. flush has priority over both.
- almost_full and almost_empty are registered, computed from the next-state count so they align with count.
- rdata is stable while rvalid && !rready.

## Timing
- Reset values (async assert, synchronous release): rvalid=0, wready=1, count=0, rdata=0, almost_full=0, almost_empty=1, pointers=0.
- Write-to-read latency into an empty FIFO: a push at edge N gives rvalid=1 with that data in the cycle after edge N. This requires a bypass into staging.
- Back-to-back pops: when count>=2 at pop edge N, the next entry is on rdata with rvalid=1 after edge N. There are no bubbles at sustained 1 push + 1 pop per cycle.
- Sustained throughput is 1 entry/cycle on each side, including across pointer wrap.
- Reset asserted mid-operation clears all state immediately. Contents are lost and the first push after release behaves as into empty.

## Test plan
- Reset then fill with SFIFODW=32, SFIFODP=16: push 0x00..0x0F on consecutive cycles with rready=0 -> count 1..16, wready=0 after 16th, almost_full rises when count=12, rvalid=1 from cycle after first push with rdata=0x00.
- Drain full FIFO with rready=1 -> rdata 0x00..0x0F on 16 consecutive cycles, no bubble, count to 0, rvalid=0 after last, almost_empty rises at count=2.
- Streaming wrap: push and pop 40 entries 0x100.. simultaneously each cycle starting from count=3 -> count stays 3, output order exact across two pointer wraps.
- Full boundary: count=16, wvalid=1 with 0xAA and rready=1 -> 0xAA not stored, count=15, wready=1 next cycle, and a later push of 0xAA is stored once.
- Single-entry boundary: count=1, push 0x55 + pop same cycle -> rvalid stays 1, rdata=0x55 next cycle, count=1.
- flush at count=9 with concurrent push and pop -> count=0, rvalid=0, wready=1 next cycle; a subsequent push 0x77 appears as rdata=0x77 one cycle later. Repeat with async rst mid-stream -> outputs at reset values immediately.
